sc_levelspeedtimer: RTL and testbench
=====================================

Name: sc_levelspeedtimer

Overview:
Downstream consumer of the 5-bit level-progress count. Converts the current level into a periodic single-cycle movement tick for the obstacle/lane shifters. The tick period shrinks linearly with level and saturates at a floor. A level change takes effect only at an interval boundary, so lanes never see a truncated or stretched step.

Parameters:
LEVELSPEEDTIMER_LEVELWIDTH, 5, width of level input
LEVELSPEEDTIMER_PERIODWIDTH, 26, width of period latch and interval counter
LEVELSPEEDTIMER_BASE_PERIOD, 25000000, period in clocks at level 0 (0.5 s at 50 MHz)
LEVELSPEEDTIMER_STEP_PERIOD, 1000000, period reduction per level
LEVELSPEEDTIMER_MIN_PERIOD, 2500000, period floor; constraint 2 <= MIN <= BASE < 2^PERIODWIDTH

Ports:
SC_LEVELSPEEDTIMER_CLOCK_50  input  1  system clock
SC_LEVELSPEEDTIMER_RESET_InHigh  input  1  asynchronous reset, active high
SC_LEVELSPEEDTIMER_Level_InBus  input  LEVELWIDTH  current level from level-progress counter
SC_LEVELSPEEDTIMER_Enable_in  input  1  game running; low = idle, no ticks
SC_LEVELSPEEDTIMER_Restart_in  input  1  synchronous restart of current interval
SC_LEVELSPEEDTIMER_Tick_Out  output  1  one-cycle movement pulse
SC_LEVELSPEEDTIMER_Period_OutBus  output  PERIODWIDTH  period latched for the running interval

Behaviour:
- One clock and one reset. The reset is asynchronous and active high. Clock port is SC_LEVELSPEEDTIMER_CLOCK_50; reset port is SC_LEVELSPEEDTIMER_RESET_InHigh.
- Reset: state=IDLE, counter=0, Tick_Out=0, period latch = BASE_PERIOD.
- Target period, combinational:
  - prod = Level * STEP, computed at full width with no truncation.
  - If prod >= BASE-MIN, target = MIN.
  - Otherwise target = BASE - prod.
- States:
  - IDLE: counter held at 0, Tick_Out=0, period latch = target every cycle. Enable_in=1 -> RUN with counter=0.
  - RUN: counter increments each clock. When counter == latch-1, the same edge does three things: counter -> 0, latch -> target, Tick_Out set to 1 for exactly the next cycle. Otherwise Tick_Out=0. Enable_in=0 -> IDLE.
- Latency: Enable sampled high at edge k gives Tick_Out high during the cycle after edge k+P (P = latched period). Subsequent ticks come every P cycles, with no dropped or merged ticks.
- Level change mid-interval: the running interval finishes with its old latch. The new target applies from the next interval.
- Restart_in=1 in RUN: counter=0, latch=target, Tick_Out=0. State is unchanged. A tick that would have fired on this edge is suppressed.
- Priority: reset > Enable_in=0 > Restart_in > count/tick.
- Enable drop mid-interval: go to IDLE, counter cleared, no tick.
- Re-enable: a full fresh interval starts; there is no partial resume.
- Reset mid-interval: return immediately to reset values.
- Period_OutBus = latch at all times.
- Counter never exceeds latch-1. No wrap beyond the period.

Test Plan:
Test parameters for all scenarios: BASE=20, STEP=2, MIN=6, PERIODWIDTH=8.
1. Reset, Level=0, Enable rises at edge k -> Period_OutBus=20; Tick_Out high only in the cycles after edges k+20, k+40, k+60; each pulse is 1 cycle wide.
2. Level sweep in IDLE at 0, 3, 7, 31 -> Period_OutBus = 20, 14, 6, 6 (saturation; no wrap at level 31).
3. RUN at Level=0; Level -> 5 at 5 cycles into the interval -> that interval still ticks after 20 cycles; the following ticks are spaced 10 cycles; Period_OutBus changes at the tick edge.
4. RUN at Level=3; Enable low at 8 cycles into the interval, high again 4 cycles later -> no tick; the next tick comes 14 cycles after re-enable.
5. RUN at Level=0; Restart_in pulsed on the edge where counter==19 -> no tick that cycle; the next tick comes 20 cycles after restart.
6. Async reset asserted mid-interval between clock edges -> Tick_Out=0, state IDLE, and Period_OutBus=20 immediately, before the next edge.

Source files
------------

// File: rtl/sc_levelspeedtimer.sv
// Level-driven movement tick generator: the level sets the tick period, which
// shrinks linearly down to a floor and is only picked up at interval boundaries.
module sc_levelspeedtimer #(
    parameter int unsigned LEVELSPEEDTIMER_LEVELWIDTH  = 5,
    parameter int unsigned LEVELSPEEDTIMER_PERIODWIDTH = 26,
    parameter int unsigned LEVELSPEEDTIMER_BASE_PERIOD = 25000000,
    parameter int unsigned LEVELSPEEDTIMER_STEP_PERIOD = 1000000,
    parameter int unsigned LEVELSPEEDTIMER_MIN_PERIOD  = 2500000
) (
    input  logic                                   SC_LEVELSPEEDTIMER_CLOCK_50,
    input  logic                                   SC_LEVELSPEEDTIMER_RESET_InHigh,
    input  logic [LEVELSPEEDTIMER_LEVELWIDTH-1:0]  SC_LEVELSPEEDTIMER_Level_InBus,
    input  logic                                   SC_LEVELSPEEDTIMER_Enable_in,
    input  logic                                   SC_LEVELSPEEDTIMER_Restart_in,
    output logic                                   SC_LEVELSPEEDTIMER_Tick_Out,
    output logic [LEVELSPEEDTIMER_PERIODWIDTH-1:0] SC_LEVELSPEEDTIMER_Period_OutBus
);

    localparam int unsigned LW    = LEVELSPEEDTIMER_LEVELWIDTH;
    localparam int unsigned PW    = LEVELSPEEDTIMER_PERIODWIDTH;
    localparam int unsigned PRODW = LW + 32;

    localparam logic [PRODW-1:0] BASE_W = PRODW'(LEVELSPEEDTIMER_BASE_PERIOD);
    localparam logic [PRODW-1:0] STEP_W = PRODW'(LEVELSPEEDTIMER_STEP_PERIOD);
    localparam logic [PRODW-1:0] SPAN_W = PRODW'(LEVELSPEEDTIMER_BASE_PERIOD - LEVELSPEEDTIMER_MIN_PERIOD);
    localparam logic [PW-1:0]    MIN_P  = PW'(LEVELSPEEDTIMER_MIN_PERIOD);
    localparam logic [PW-1:0]    BASE_P = PW'(LEVELSPEEDTIMER_BASE_PERIOD);
    localparam logic [PW-1:0]    ONE_P  = PW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   count, count_next;
    logic [PW-1:0]   latch, latch_next;
    logic            tick, tick_next;
    logic [PRODW-1:0] prod;
    logic [PW-1:0]   target;
    logic            count_last;

    // Product is held wide enough that large levels saturate instead of wrapping.
    always_comb begin
        prod   = PRODW'(SC_LEVELSPEEDTIMER_Level_InBus) * STEP_W;
        target = MIN_P;
        if (prod < SPAN_W) begin
            target = PW'(BASE_W - prod);
        end
    end

    assign count_last = (count == (latch - ONE_P));

    always_ff @(posedge SC_LEVELSPEEDTIMER_CLOCK_50 or posedge SC_LEVELSPEEDTIMER_RESET_InHigh) begin
        if (SC_LEVELSPEEDTIMER_RESET_InHigh) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        latch_next = latch;
        tick_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                count_next = '0;
                latch_next = target;
                if (SC_LEVELSPEEDTIMER_Enable_in) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!SC_LEVELSPEEDTIMER_Enable_in) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    latch_next = target;
                end else if (SC_LEVELSPEEDTIMER_Restart_in) begin
                    count_next = '0;
                    latch_next = target;
                end else if (count_last) begin
                    count_next = '0;
                    latch_next = target;
                    tick_next  = 1'b1;
                end else begin
                    count_next = count + ONE_P;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
                latch_next = target;
            end
        endcase
    end

    always_ff @(posedge SC_LEVELSPEEDTIMER_CLOCK_50 or posedge SC_LEVELSPEEDTIMER_RESET_InHigh) begin
        if (SC_LEVELSPEEDTIMER_RESET_InHigh) begin
            count <= '0;
            latch <= BASE_P;
            tick  <= 1'b0;
        end else begin
            count <= count_next;
            latch <= latch_next;
            tick  <= tick_next;
        end
    end

    assign SC_LEVELSPEEDTIMER_Tick_Out       = tick;
    assign SC_LEVELSPEEDTIMER_Period_OutBus  = latch;

endmodule

// File: tb/tb_sc_levelspeedtimer.sv
// Bench for sc_levelspeedtimer: timeline model of interval starts and periods,
// checked every cycle, plus directed scenarios with literal tick positions.
module tb_sc_levelspeedtimer;

    localparam int BASE = 20;
    localparam int STEP = 2;
    localparam int MINP = 6;
    localparam int PW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    lvl = '0;
    logic          en  = 1'b0;
    logic          rs  = 1'b0;
    logic          tick;
    logic [PW-1:0] period;

    int tests = 0;
    int fails = 0;

    sc_levelspeedtimer #(
        .LEVELSPEEDTIMER_LEVELWIDTH (5),
        .LEVELSPEEDTIMER_PERIODWIDTH(PW),
        .LEVELSPEEDTIMER_BASE_PERIOD(BASE),
        .LEVELSPEEDTIMER_STEP_PERIOD(STEP),
        .LEVELSPEEDTIMER_MIN_PERIOD (MINP)
    ) dut (
        .SC_LEVELSPEEDTIMER_CLOCK_50    (clk),
        .SC_LEVELSPEEDTIMER_RESET_InHigh(rst),
        .SC_LEVELSPEEDTIMER_Level_InBus (lvl),
        .SC_LEVELSPEEDTIMER_Enable_in   (en),
        .SC_LEVELSPEEDTIMER_Restart_in  (rs),
        .SC_LEVELSPEEDTIMER_Tick_Out    (tick),
        .SC_LEVELSPEEDTIMER_Period_OutBus(period)
    );

    always #5 clk = ~clk;

    function automatic int target(input int l);
        int p;
        p = l * STEP;
        return (p >= BASE - MINP) ? MINP : BASE - p;
    endfunction

    // Model: an interval starting at edge s with period P ticks on edge s+P.
    int edge_cnt = 0;
    int m_start  = 0;
    int m_period = BASE;
    bit m_run    = 1'b0;
    bit m_tick   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run    = 1'b0;
            m_period = BASE;
            m_tick   = 1'b0;
        end else begin
            edge_cnt = edge_cnt + 1;
            m_tick   = 1'b0;
            if (!m_run) begin
                m_period = target(int'(lvl));
                if (en) begin
                    m_run   = 1'b1;
                    m_start = edge_cnt;
                end
            end else if (!en) begin
                m_run    = 1'b0;
                m_period = target(int'(lvl));
            end else if (rs) begin
                m_start  = edge_cnt;
                m_period = target(int'(lvl));
            end else if (edge_cnt - m_start == m_period) begin
                m_tick   = 1'b1;
                m_start  = edge_cnt;
                m_period = target(int'(lvl));
            end
        end
    end

    int tick_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tq(input int i);
        return (i < tick_q.size()) ? tick_q[i] : -1;
    endfunction

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model_tick", int'(tick), int'(m_tick));
                check("model_period", int'(period), m_period);
                if (tick) tick_q.push_back(edge_cnt);
            end
        end
    endtask

    int k;
    int r;
    bit got;
    int sweep_lvl[4] = '{0, 3, 7, 31};
    int sweep_exp[4] = '{20, 14, 6, 6};

    initial begin
        fork
            cmp_loop();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tick", int'(tick), 0);
        check("rst_period", int'(period), 20);
        rst = 1'b0;

        // 1: level 0, ticks at k+20, k+40, k+60
        @(negedge clk);
        check("t1_idle_period", int'(period), 20);
        tick_q.delete();
        en = 1'b1;
        k  = edge_cnt + 1;
        repeat (65) @(negedge clk);
        #1;
        check("t1_count", tick_q.size(), 3);
        check("t1_tick0", tq(0), k + 20);
        check("t1_tick1", tq(1), k + 40);
        check("t1_tick2", tq(2), k + 60);

        // 2: idle sweep with saturation
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lvl = 5'(sweep_lvl[i]);
            repeat (2) @(negedge clk);
            check("t2_sweep_period", int'(period), sweep_exp[i]);
        end

        // 3: level change mid-interval takes effect at next interval
        lvl = 5'd0;
        repeat (2) @(negedge clk);
        tick_q.delete();
        en = 1'b1;
        k  = edge_cnt + 1;
        repeat (6) @(negedge clk);
        lvl = 5'd5;
        repeat (40) @(negedge clk);
        #1;
        check("t3_count", tick_q.size(), 3);
        check("t3_tick0", tq(0), k + 20);
        check("t3_tick1", tq(1), k + 30);
        check("t3_tick2", tq(2), k + 40);
        check("t3_period", int'(period), 10);

        // 4: enable drop and re-enable restarts a full interval
        en  = 1'b0;
        lvl = 5'd3;
        repeat (2) @(negedge clk);
        tick_q.delete();
        en = 1'b1;
        k  = edge_cnt + 1;
        repeat (9) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        r  = edge_cnt + 1;
        repeat (16) @(negedge clk);
        #1;
        check("t4_reenable_gap", r - k, 13);
        check("t4_count", tick_q.size(), 1);
        check("t4_tick0", tq(0), r + 14);

        // 5: restart on the would-be tick edge suppresses it
        en  = 1'b0;
        lvl = 5'd0;
        repeat (2) @(negedge clk);
        tick_q.delete();
        en = 1'b1;
        k  = edge_cnt + 1;
        repeat (20) @(negedge clk);
        rs = 1'b1;
        @(negedge clk);
        rs = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        check("t5_count", tick_q.size(), 1);
        check("t5_tick0", tq(0), k + 40);

        // 6: async reset between edges while a tick is high
        en  = 1'b0;
        lvl = 5'd3;
        repeat (2) @(negedge clk);
        en  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (tick) got = 1'b1;
        end
        check("t6_tick_seen", int'(got), 1);
        check("t6_pre_period", int'(period), 14);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_tick", int'(tick), 0);
        check("t6_async_period", int'(period), 20);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_period", int'(period), 14);
        tick_q.delete();
        repeat (25) @(negedge clk);
        #1;
        check("t6_no_ticks", tick_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
